serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  clock. All state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset. One clock, synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  addend A (unsigned), captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  addend B (unsigned), captured on accepted start.
REQ-007 SHALL have port Cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port S  output  WIDTH  registered sum.
REQ-009 SHALL have port Cout  output  1  registered carry-out.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-011 SHALL have port done  output  1  single-cycle pulse marking S/Cout valid.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 at an edge SHALL capture a, b, Cin into internal shift/carry registers, clear bit counter to 0, go to RUN; start=0 stays IDLE.
REQ-014 RUN: each edge SHALL compute one result bit, LSB first: s_i = a_i ^ b_i ^ c, c <= majority(a_i, b_i, c), shift operands right, shift s_i into the result MSB.
REQ-015 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge load S with the full result, Cout with the final carry, go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-017 Latency: start accepted at edge t0 -> done=1 during the cycle after edge t0+WIDTH; S/Cout valid from that cycle.
REQ-018 S and Cout SHALL hold their value until the next operation's WIDTH-th RUN edge; not disturbed while RUN is in progress.
REQ-019 Result SHALL equal {Cout,S} = a + b + Cin modulo 2^(WIDTH+1), using the captured operands.
REQ-020 start while busy=1 SHALL be ignored (no queuing); changes on a, b, Cin after capture SHALL have no effect.
REQ-021 start held high continuously SHALL produce back-to-back operations, one accepted per IDLE cycle (period WIDTH+2).
REQ-022 busy SHALL be 1 in RUN and DONE, 0 in IDLE.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, S=0, Cout=0, busy=0, done=0, clear counter, carry, and shift registers; overrides start.
REQ-024 rst during RUN or DONE SHALL abort the operation with no done pulse; rst has priority over every other event.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: SHALL add output port Ovf (1 bit) = two's-complement overflow of the operation (carry into MSB XOR carry out of MSB), registered and updated with S, reset 0.
REQ-026 Macro SERIAL_ADDER_OVF_EN undefined: Ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 WIDTH=8, a=0x0F b=0x01 Cin=0, start 1 cycle -> done after 9 cycles, S=0x10 Cout=0.
REQ-028 WIDTH=8, a=0xFF b=0x01 Cin=0 -> S=0x00 Cout=1; a=0xFF b=0xFF Cin=1 -> S=0xFF Cout=1.
REQ-029 Start a=0x12 b=0x34, then during RUN pulse start with a=0xAA b=0xAA and change a/b -> only one done, S=0x46 Cout=0, busy stays 1 throughout.
REQ-030 rst=1 at 4th RUN cycle of a=0xFF b=0xFF -> next cycle IDLE, S=0 Cout=0 busy=0, no done pulse.
REQ-031 start held high, operands 0x01+0x01 then 0x80+0x80 -> done every 10 cycles, S=0x02 Cout=0 then S=0x00 Cout=1.
REQ-032 With SERIAL_ADDER_OVF_EN: a=0x7F b=0x01 -> S=0x80 Ovf=1 Cout=0; a=0x80 b=0x80 -> S=0x00 Ovf=1 Cout=1; a=0x01 b=0x01 -> Ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b, Cin on start and adds one bit per clock, LSB first.
// Optional Ovf output (two's-complement overflow) is enabled by defining SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; S/Cout hold the last result
// RUN   | one sum bit per edge, WIDTH edges in total
// DONE  | single cycle with done=1, S/Cout valid
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic sum_bit;
    logic carry_next;

    assign sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= Cin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= carry_next;
                    res   <= {sum_bit, res[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // last bit goes straight into S; res is only a staging shift register
                        S     <= {sum_bit, res[WIDTH-1:1]};
                        Cout  <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        Ovf   <= carry ^ carry_next;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus busy-start, reset-abort
// and back-to-back sequences. Define SERIAL_ADDER_OVF_EN to also check Ovf.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;
    logic         busy;
    logic         done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] prev_s;
    int           lat;
    int           n_done;
    int           d1;
    int           d2;

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0};

        // reset must win over a pending start
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; Cin = 1'b1;
        tick(); tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_s",    32'(S),    32'd0);
        check("reset_cout", 32'(Cout), 32'd0);
        start = 1'b0; rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        prev_s = '0;

        for (int i = 0; i < 9; i++) begin
            a = vecs[i].va; b = vecs[i].vb; Cin = vecs[i].vcin; start = 1'b1;
            tick();
            start = 1'b0;
            a = ~vecs[i].va; b = ~vecs[i].vb; Cin = ~vecs[i].vcin;
            check($sformatf("v%0d_busy_run", i), 32'(busy), 32'd1);
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                tick();
                if (c == 4) check($sformatf("v%0d_s_hold", i), 32'(S), 32'(prev_s));
                if (done) begin
                    lat = c;
                    break;
                end
            end
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
            check($sformatf("v%0d_s", i), 32'(S), 32'(vecs[i].exp_s));
            check($sformatf("v%0d_cout", i), 32'(Cout), 32'(vecs[i].exp_cout));
            check($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(Ovf), 32'(vecs[i].exp_ovf));
`endif
            tick();
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_s_keep", i), 32'(S), 32'(vecs[i].exp_s));
            prev_s = vecs[i].exp_s;
        end

        // start during RUN is ignored; operands changed after capture have no effect
        a = 8'h12; b = 8'h34; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 2 * W + 4; c++) begin
            if (c == 3) begin start = 1'b1; a = 8'hAA; b = 8'hAA; end
            if (c == 4) begin start = 1'b0; a = 8'h55; b = 8'hF0; end
            tick();
            if (done) n_done++;
            if (c <= W) check($sformatf("busy_hold_c%0d", c), 32'(busy), 32'd1);
            if (done) begin
                check("busy_start_s", 32'(S), 32'h46);
                check("busy_start_cout", 32'(Cout), 32'd0);
            end
        end
        check("busy_start_ndone", 32'(n_done), 32'd1);

        // reset at the 4th RUN edge aborts with no done pulse
        a = 8'hFF; b = 8'hFF; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s",    32'(S),    32'd0);
        check("abort_cout", 32'(Cout), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        n_done = 0;
        for (int c = 0; c < 2 * W; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("abort_quiet", 32'(n_done), 32'd0);

        // start held high: back-to-back operations, period W+2
        d1 = -1; d2 = -1;
        a = 8'h01; b = 8'h01; Cin = 1'b0; start = 1'b1;
        for (int c = 1; c <= 40 && d2 < 0; c++) begin
            tick();
            if (c == 1) begin a = 8'h80; b = 8'h80; end
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check("b2b_s1", 32'(S), 32'h02);
                    check("b2b_cout1", 32'(Cout), 32'd0);
                end else begin
                    d2 = c;
                    start = 1'b0;
                    check("b2b_s2", 32'(S), 32'h00);
                    check("b2b_cout2", 32'(Cout), 32'd1);
                end
            end
        end
        check("b2b_first_done", 32'(d1), 32'(W + 1));
        check("b2b_period", 32'(d2 - d1), 32'(W + 2));
        tick(); tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
